// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the ID-stage NZCV status / flag-hazard block.
package cond_flag_unit_pkg;

    // Bit positions inside a {N,Z,C,V} nibble
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Stall FSM encoding; the state bit is exported directly as stall_state
    typedef enum logic {
        StRun  = 1'b0,
        StWait = 1'b1
    } stall_state_e;

    // NV is treated like AL: neither consumes the flags
    function automatic logic is_unconditional(input logic [3:0] cond, input logic [3:0] al_code);
        return (cond == al_code) || (cond == COND_NV);
    endfunction

endpackage

// File: rtl/cond_flag_unit_if.sv
// Pipeline-side bundle for cond_flag_unit: ID/EXE inputs and status/stall outputs.
interface cond_flag_unit_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [3:0]             id_cond;
    logic                   exe_valid;
    logic                   exe_s;
    logic [3:0]             exe_flags;
    logic                   exe_hold;
    logic                   flush;
    logic [3:0]             status_q;
    logic [3:0]             cond_flags;
    logic                   flag_stall;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   stall_state;

    // Pipeline side
    modport master (
        output id_valid, id_cond, exe_valid, exe_s, exe_flags, exe_hold, flush,
        input  status_q, cond_flags, flag_stall, stall_cnt, stall_state
    );

    // Flag unit side
    modport slave (
        input  id_valid, id_cond, exe_valid, exe_s, exe_flags, exe_hold, flush,
        output status_q, cond_flags, flag_stall, stall_cnt, stall_state
    );
endinterface

// File: rtl/cond_flag_unit_flag_hazard_detect.sv
// Combinational flag-hazard detection: decides whether the ID instruction must
// stall on an in-flight S-bit instruction, or (bypass builds) take EXE's flags.
module cond_flag_unit_flag_hazard_detect
    import cond_flag_unit_pkg::*;
#(
    parameter logic [3:0] AL_CODE = COND_AL,
    parameter bit         FWD_EN  = 1'b0
) (
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    input  logic       exe_valid,
    input  logic       exe_s,
    input  logic       exe_hold,
    input  logic       flush,
    output logic       stall,
    output logic       fwd_sel
);
    logic id_reads;
    logic pending;
    logic hazard;

    // Hazard when ID consumes flags that a live EXE S-bit op has yet to write
    always_comb begin
        id_reads = id_valid & ~is_unconditional(id_cond, AL_CODE);
        pending  = exe_valid & exe_s & ~flush;
        hazard   = id_reads & pending;
        // Bypass is only legal when EXE is not frozen, i.e. its flags are final
        fwd_sel  = FWD_EN & hazard & ~exe_hold;
        stall    = hazard & ~fwd_sel;
    end

endmodule

// File: rtl/cond_flag_unit.sv
// ID-stage NZCV status register with flag-hazard stall, stall FSM and
// saturating stall-cycle counter. Optional EXE->ID flag bypass when the
// FLAG_FORWARD_EN macro is defined.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16,
    parameter logic [3:0]  AL_CODE     = COND_AL
) (
    input  logic             clk,
    input  logic             rst,
    cond_flag_unit_if.slave  bus
);
`ifdef FLAG_FORWARD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic [3:0]             status_q;
    logic [STALL_CNT_W-1:0] cnt_q;
    stall_state_e           state_q;
    logic                   stall;
    logic                   fwd_sel;
    logic                   commit;

    cond_flag_unit_flag_hazard_detect #(
        .AL_CODE (AL_CODE),
        .FWD_EN  (FwdEn)
    ) u_hazard (
        .id_valid  (bus.id_valid),
        .id_cond   (bus.id_cond),
        .exe_valid (bus.exe_valid),
        .exe_s     (bus.exe_s),
        .exe_hold  (bus.exe_hold),
        .flush     (bus.flush),
        .stall     (stall),
        .fwd_sel   (fwd_sel)
    );

    // EXE writes flags only when it actually leaves the stage unsquashed
    always_comb begin
        commit = bus.exe_valid & bus.exe_s & ~bus.exe_hold & ~bus.flush;
    end

    // Status register, stall FSM and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 4'b0000;
            cnt_q    <= '0;
            state_q  <= StRun;
        end else begin
            if (commit) begin
                status_q <= bus.exe_flags;
            end
            if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            unique case (state_q)
                StRun:   if (stall)  state_q <= StWait;
                StWait:  if (!stall) state_q <= StRun;
                default: state_q <= StRun;
            endcase
            if (bus.flush) begin
                state_q <= StRun;
            end
        end
    end

    // Outputs: stall is same-cycle combinational, flags come from the register
    // unless the bypass path is selected
    always_comb begin
        bus.status_q    = status_q;
        bus.cond_flags  = fwd_sel ? bus.exe_flags : status_q;
        bus.flag_stall  = stall;
        bus.stall_cnt   = cnt_q;
        bus.stall_state = state_q;
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed scenarios plus randomized
// traffic against a behavioural model. Follows FLAG_FORWARD_EN like the DUT.
module tb_cond_flag_unit;

    localparam int W       = 6;
    localparam int CNT_MAX = (1 << W) - 1;
`ifdef FLAG_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cond_flag_unit_if #(.STALL_CNT_W(W)) bus ();

    cond_flag_unit #(.STALL_CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [3:0] m_status;
    int         m_cnt;
    bit         m_wait;

    function automatic bit exp_hazard();
        bit reads;
        reads = bus.id_valid && (bus.id_cond != 4'hE) && (bus.id_cond != 4'hF);
        return reads && bus.exe_valid && bus.exe_s && !bus.flush;
    endfunction

    function automatic bit exp_stall();
        if (FWD) return exp_hazard() && bus.exe_hold;
        return exp_hazard();
    endfunction

    function automatic logic [3:0] exp_cond();
        if (FWD && exp_hazard() && !bus.exe_hold) return bus.exe_flags;
        return m_status;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic step();
        bit s;
        s = exp_stall();
        @(posedge clk);
        if (rst) begin
            m_status = 4'b0000;
            m_cnt    = 0;
            m_wait   = 1'b0;
        end else begin
            if (bus.exe_valid && bus.exe_s && !bus.exe_hold && !bus.flush)
                m_status = bus.exe_flags;
            if (s && m_cnt < CNT_MAX) m_cnt++;
            m_wait = s;
        end
        #1;
    endtask

    task automatic idle();
        bus.id_valid  = 1'b0;
        bus.id_cond   = 4'h0;
        bus.exe_valid = 1'b0;
        bus.exe_s     = 1'b0;
        bus.exe_flags = 4'h0;
        bus.exe_hold  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        #1;
        checks++; if (bus.status_q !== 4'b0000) $display("FAIL reset_status got %b want 0000", bus.status_q); else passed++;
        checks++; if (bus.stall_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", bus.stall_cnt); else passed++;
        checks++; if (bus.stall_state !== 1'b0) $display("FAIL reset_state got %b want 0", bus.stall_state); else passed++;
        checks++; if (bus.flag_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.flag_stall); else passed++;
    endtask

    task automatic test_single_stall();
        do_reset();
        bus.id_valid = 1'b1; bus.id_cond = 4'b0000;
        bus.exe_valid = 1'b1; bus.exe_s = 1'b1; bus.exe_flags = 4'b0100;
        #1;
        checks++; if (bus.flag_stall !== !FWD) $display("FAIL single_stall got %b want %b", bus.flag_stall, !FWD); else passed++;
        checks++; if (bus.cond_flags !== (FWD ? 4'b0100 : 4'b0000)) $display("FAIL single_cond got %b want %b", bus.cond_flags, FWD ? 4'b0100 : 4'b0000); else passed++;
        step();
        bus.exe_valid = 1'b0; bus.exe_s = 1'b0; // bubble
        #1;
        checks++; if (bus.status_q !== 4'b0100) $display("FAIL single_status got %b want 0100", bus.status_q); else passed++;
        checks++; if (bus.flag_stall !== 1'b0) $display("FAIL single_release got %b want 0", bus.flag_stall); else passed++;
        checks++; if (bus.stall_cnt !== W'(FWD ? 0 : 1)) $display("FAIL single_cnt got %0d want %0d", bus.stall_cnt, FWD ? 0 : 1); else passed++;
        checks++; if (bus.stall_state !== !FWD) $display("FAIL single_state got %b want %b", bus.stall_state, !FWD); else passed++;
        step();
        idle();
    endtask

    task automatic test_hold_stall();
        int stalls;
        do_reset();
        stalls = 0;
        bus.id_valid = 1'b1; bus.id_cond = 4'b0000;
        bus.exe_valid = 1'b1; bus.exe_s = 1'b1; bus.exe_flags = 4'b0100;
        bus.exe_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.flag_stall !== 1'b1) $display("FAIL hold_stall[%0d] got %b want 1", i, bus.flag_stall); else passed++;
            if (bus.flag_stall === 1'b1) stalls++;
            step();
            checks++; if (bus.status_q !== 4'b0000) $display("FAIL hold_status[%0d] got %b want 0000", i, bus.status_q); else passed++;
        end
        bus.exe_hold = 1'b0;
        #1;
        if (bus.flag_stall === 1'b1) stalls++;
        step();
        bus.exe_valid = 1'b0; bus.exe_s = 1'b0;
        #1;
        checks++; if (stalls !== (FWD ? 3 : 4)) $display("FAIL hold_stall_cycles got %0d want %0d", stalls, FWD ? 3 : 4); else passed++;
        checks++; if (bus.status_q !== 4'b0100) $display("FAIL hold_commit got %b want 0100", bus.status_q); else passed++;
        checks++; if (bus.stall_cnt !== W'(FWD ? 3 : 4)) $display("FAIL hold_cnt got %0d want %0d", bus.stall_cnt, FWD ? 3 : 4); else passed++;
        step();
        idle();
    endtask

    task automatic test_flush_and_al();
        do_reset();
        bus.id_valid = 1'b1; bus.id_cond = 4'b0001;
        bus.exe_valid = 1'b1; bus.exe_s = 1'b1; bus.exe_flags = 4'b1111; bus.flush = 1'b1;
        #1;
        checks++; if (bus.flag_stall !== 1'b0) $display("FAIL flush_stall got %b want 0", bus.flag_stall); else passed++;
        step();
        checks++; if (bus.status_q !== 4'b0000) $display("FAIL flush_nowrite got %b want 0000", bus.status_q); else passed++;
        bus.flush = 1'b0; bus.id_cond = 4'b1110; bus.exe_flags = 4'b0010;
        #1;
        checks++; if (bus.flag_stall !== 1'b0) $display("FAIL al_stall got %b want 0", bus.flag_stall); else passed++;
        bus.id_cond = 4'b1111;
        #1;
        checks++; if (bus.flag_stall !== 1'b0) $display("FAIL nv_stall got %b want 0", bus.flag_stall); else passed++;
        step();
        checks++; if (bus.stall_state !== 1'b0) $display("FAIL al_state got %b want 0", bus.stall_state); else passed++;
        checks++; if (bus.status_q !== 4'b0010) $display("FAIL al_commit got %b want 0010", bus.status_q); else passed++;
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.id_valid = 1'b1; bus.id_cond = 4'b0011;
        bus.exe_valid = 1'b1; bus.exe_s = 1'b1; bus.exe_flags = 4'b1000; bus.exe_hold = 1'b1;
        for (int i = 0; i < CNT_MAX + 3; i++) step();
        checks++; if (bus.stall_cnt !== W'(CNT_MAX)) $display("FAIL sat_cnt got %0d want %0d", bus.stall_cnt, CNT_MAX); else passed++;
        checks++; if (bus.stall_state !== 1'b1) $display("FAIL sat_state got %b want 1", bus.stall_state); else passed++;
        // Reset mid-stall wins and leaves a purely combinational stall
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.stall_state !== 1'b0) $display("FAIL rst_mid_state got %b want 0", bus.stall_state); else passed++;
        checks++; if (bus.stall_cnt !== '0) $display("FAIL rst_mid_cnt got %0d want 0", bus.stall_cnt); else passed++;
        checks++; if (bus.flag_stall !== 1'b1) $display("FAIL rst_mid_stall got %b want 1", bus.flag_stall); else passed++;
        idle();
        step();
    endtask

`ifdef FLAG_FORWARD_EN
    task automatic test_forward();
        do_reset();
        bus.id_valid = 1'b1; bus.id_cond = 4'b1011;
        bus.exe_valid = 1'b1; bus.exe_s = 1'b1; bus.exe_flags = 4'b1001;
        #1;
        checks++; if (bus.flag_stall !== 1'b0) $display("FAIL fwd_stall got %b want 0", bus.flag_stall); else passed++;
        checks++; if (bus.cond_flags !== 4'b1001) $display("FAIL fwd_cond got %b want 1001", bus.cond_flags); else passed++;
        bus.exe_hold = 1'b1;
        #1;
        checks++; if (bus.flag_stall !== 1'b1) $display("FAIL fwd_hold_stall got %b want 1", bus.flag_stall); else passed++;
        checks++; if (bus.cond_flags !== 4'b0000) $display("FAIL fwd_hold_cond got %b want 0000", bus.cond_flags); else passed++;
        step();
        idle();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            bus.id_valid  = ($urandom_range(0, 3) != 0);
            bus.id_cond   = 4'($urandom_range(0, 15));
            bus.exe_valid = ($urandom_range(0, 3) != 0);
            bus.exe_s     = ($urandom_range(0, 2) != 0);
            bus.exe_flags = 4'($urandom_range(0, 15));
            bus.exe_hold  = ($urandom_range(0, 3) == 0);
            bus.flush     = ($urandom_range(0, 5) == 0);
            #1;
            checks++; if (bus.flag_stall !== exp_stall()) $display("FAIL rnd_stall[%0d] got %b want %b", i, bus.flag_stall, exp_stall()); else passed++;
            checks++; if (bus.cond_flags !== exp_cond()) $display("FAIL rnd_cond[%0d] got %b want %b", i, bus.cond_flags, exp_cond()); else passed++;
            step();
            checks++; if (bus.status_q !== m_status) $display("FAIL rnd_status[%0d] got %b want %b", i, bus.status_q, m_status); else passed++;
            checks++; if (bus.stall_cnt !== W'(m_cnt)) $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, bus.stall_cnt, m_cnt); else passed++;
            checks++; if (bus.stall_state !== m_wait) $display("FAIL rnd_state[%0d] got %b want %b", i, bus.stall_state, m_wait); else passed++;
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        m_status = 4'b0000;
        m_cnt    = 0;
        m_wait   = 1'b0;
        idle();
        test_reset();
        test_single_stall();
        test_hold_stall();
        test_flush_and_al();
        test_saturation();
`ifdef FLAG_FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
